// File: rtl/xbee_pkt_rx.sv
// xbee_pkt_rx: receives SOF/TYPE/ARG/CHK frames from the xbee UART byte stream.
// It holds one packet until the consumer acks it, counts checksum failures and
// inter-byte timeouts, and keeps a sticky flag for good packets that were dropped.
module xbee_pkt_rx #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_rdy,
  output logic [7:0] pkt_type,
  output logic [7:0] pkt_arg,
  output logic       pkt_valid,
  input  logic       pkt_ack,
  output logic [7:0] chk_err_cnt,
  output logic [7:0] to_err_cnt,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // The timeout fires on the idle cycle that would take the count to TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GET_TYPE, GET_ARG, GET_CHK} state_t;

  state_t          state, state_nxt;
  logic [7:0]      stg_type, stg_arg;
  logic [7:0]      chk_sum;
  logic [TW-1:0]   to_cnt;
  logic            timeout;
  logic            load;

  assign chk_sum = stg_type + stg_arg;

  // Next-state decode; a byte strobe always takes priority over a timeout.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    load      = 1'b0;
    if (data_rdy) begin
      case (state)
        IDLE:     if (data_in == SOF_BYTE) state_nxt = GET_TYPE;
        GET_TYPE: state_nxt = GET_ARG;
        GET_ARG:  state_nxt = GET_CHK;
        GET_CHK: begin
          state_nxt = IDLE;
          load      = (data_in == chk_sum);
        end
        default:  state_nxt = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      timeout   = 1'b1;
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Staging bytes and the inter-byte idle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_type <= '0;
      stg_arg  <= '0;
      to_cnt   <= '0;
    end else begin
      if (data_rdy && state == GET_TYPE) stg_type <= data_in;
      if (data_rdy && state == GET_ARG)  stg_arg  <= data_in;
      if (timeout) begin
        stg_type <= '0;
        stg_arg  <= '0;
      end
      if (data_rdy || timeout || state == IDLE) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Held packet: load when free or being acked in the same cycle, else drop and flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_type  <= '0;
      pkt_arg   <= '0;
      pkt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      if (!pkt_valid || pkt_ack) begin
        pkt_type  <= stg_type;
        pkt_arg   <= stg_arg;
        pkt_valid <= 1'b1;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (pkt_valid && pkt_ack) begin
      pkt_valid <= 1'b0;
    end
  end

  // Saturating error counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_err_cnt <= '0;
      to_err_cnt  <= '0;
    end else begin
      if (state == GET_CHK && data_rdy && !load && chk_err_cnt != '1)
        chk_err_cnt <= chk_err_cnt + 1'b1;
      if (timeout && to_err_cnt != '1)
        to_err_cnt <= to_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xbee_pkt_rx.sv
// Directed bench for xbee_pkt_rx; expected packets go through a scoreboard queue.
module tb_xbee_pkt_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_rdy;
  logic [7:0] pkt_type, pkt_arg;
  logic       pkt_valid;
  logic       pkt_ack;
  logic [7:0] chk_err_cnt, to_err_cnt;
  logic       overflow;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] sb[$];

  xbee_pkt_rx #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_rdy(data_rdy),
    .pkt_type(pkt_type), .pkt_arg(pkt_arg), .pkt_valid(pkt_valid),
    .pkt_ack(pkt_ack), .chk_err_cnt(chk_err_cnt), .to_err_cnt(to_err_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected packet and compare it with the held one.
  task automatic check_pkt(input string tag);
    logic [15:0] e;
    check({tag, "_valid"}, 32'(pkt_valid), 32'd1);
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sb: observed empty expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_type"}, 32'(pkt_type), 32'(e[15:8]));
      check({tag, "_arg"},  32'(pkt_arg),  32'(e[7:0]));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in  = b;
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] a, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(t);
    send_byte(a);
    send_byte(c);
  endtask

  task automatic ack;
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; data_in = '0; data_rdy = 1'b0; pkt_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pkt_valid), 0);
    check("rst_type", 32'(pkt_type), 0);
    check("rst_arg", 32'(pkt_arg), 0);
    check("rst_chk", 32'(chk_err_cnt), 0);
    check("rst_to", 32'(to_err_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;

    // Basic good frame, then ack.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
    check("t1_pre", 32'(pkt_valid), 0);
    sb.push_back(16'h0312);
    send_byte(8'h15);
    check_pkt("t1");
    ack;
    check("t1_ack", 32'(pkt_valid), 0);

    // Bad checksum, then junk byte before a good frame.
    send_frame(8'h03, 8'h12, 8'h16);
    check("t2_novalid", 32'(pkt_valid), 0);
    check("t2_chkerr", 32'(chk_err_cnt), 1);
    send_byte(8'h7F);
    sb.push_back(16'h0101);
    send_frame(8'h01, 8'h01, 8'h02);
    check_pkt("t2");
    check("t2_chkerr2", 32'(chk_err_cnt), 1);
    ack;

    // Overflow: second good frame dropped while first unacked.
    sb.push_back(16'h1020);
    send_frame(8'h10, 8'h20, 8'h30);
    check("t3_ovf0", 32'(overflow), 0);
    send_frame(8'h11, 8'h22, 8'h33);
    check_pkt("t3_keep");
    check("t3_ovf1", 32'(overflow), 1);
    // Third frame's CHK coincides with ack: new packet loaded, still valid.
    send_byte(8'hA5); send_byte(8'h44); send_byte(8'h55);
    @(negedge clk);
    data_in = 8'h99; data_rdy = 1'b1; pkt_ack = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0; pkt_ack = 1'b0;
    sb.push_back(16'h4455);
    check_pkt("t3_ackload");
    check("t3_ovf_stay", 32'(overflow), 1);
    ack;
    check("t3_ack", 32'(pkt_valid), 0);

    // SOF value captured mid-frame as TYPE.
    sb.push_back(16'hA501);
    send_frame(8'hA5, 8'h01, 8'hA6);
    check_pkt("t4_sofmid");
    ack;

    // Timeout after A5,04 with 10 idle clocks.
    send_byte(8'hA5); send_byte(8'h04);
    repeat (9) @(negedge clk);
    check("t5_to_early", 32'(to_err_cnt), 0);
    @(negedge clk);
    check("t5_to", 32'(to_err_cnt), 1);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h0B);
    check("t5_nopkt", 32'(pkt_valid), 0);
    check("t5_chk", 32'(chk_err_cnt), 1);
    check("t5_to2", 32'(to_err_cnt), 1);

    // Checksum error saturation.
    for (int i = 0; i < 256; i++) send_frame(8'h01, 8'h01, 8'h00);
    check("t6_sat", 32'(chk_err_cnt), 255);
    check("t6_novalid", 32'(pkt_valid), 0);

    // Reset mid-frame, then a fresh frame.
    send_byte(8'hA5); send_byte(8'h02);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t7_valid", 32'(pkt_valid), 0);
    check("t7_type", 32'(pkt_type), 0);
    check("t7_arg", 32'(pkt_arg), 0);
    check("t7_chk", 32'(chk_err_cnt), 0);
    check("t7_to", 32'(to_err_cnt), 0);
    check("t7_ovf", 32'(overflow), 0);
    reset = 1'b1;
    sb.push_back(16'h0203);
    send_frame(8'h02, 8'h03, 8'h05);
    check_pkt("t7");
    check("t7_chk2", 32'(chk_err_cnt), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
